// File: rtl/ola_pkg.sv
// Shared types and helpers for the overlap-add synthesis stage.
//   ola_state_e  : control FSM states (clear / accumulate / drain)
//   ola_addr_w   : accumulator RAM address width for a given frame length
//   ola_acc_w    : accumulator word width (input width + overlap growth + sign guard)
//   sat_to_width : clamp a signed value to a signed width, reporting whether it clamped
package ola_pkg;

    typedef enum logic [1:0] {
        StClear = 2'd0,
        StAccum = 2'd1,
        StDrain = 2'd2
    } ola_state_e;

    function automatic int unsigned ola_addr_w(input int unsigned fft_len);
        return $clog2(fft_len);
    endfunction

    // Up to FFT_LEN/HOP frames overlap on any one buffer word.
    function automatic int unsigned ola_acc_w(input int unsigned data_w,
                                              input int unsigned fft_len,
                                              input int unsigned hop);
        return data_w + $clog2(fft_len / hop) + 1;
    endfunction

    function automatic longint sat_to_width(input  longint      value,
                                            input  int unsigned width,
                                            output logic        clamped);
        longint hi;
        longint lo;
        longint res;
        hi      = (longint'(1) <<< (width - 1)) - longint'(1);
        lo      = -(longint'(1) <<< (width - 1));
        res     = value;
        clamped = 1'b0;
        if (value > hi) begin
            res     = hi;
            clamped = 1'b1;
        end else if (value < lo) begin
            res     = lo;
            clamped = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ola_accum_ram.sv
// Simple dual-port accumulator RAM: one write port, one read port with a
// registered (1-cycle) read. Read-during-write to the same address returns
// the old contents. No reset, so it maps onto block RAM.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (sampled every cycle)
//   rdata_o : read data, valid the cycle after raddr_i
module ola_accum_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 21,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/overlap_add_synth.sv
// Overlap-add synthesis stage following the IFFT core. One frame of FFT_LEN
// samples (any index order) is added into a circular accumulator at the current
// hop position, then HOP finished samples are drained as audio and cleared.
//
// Build option: define OVERLAP_ADD_SATURATE_EN to clamp output samples and
// drive a sticky sat_flag; otherwise samples wrap and sat_flag stays 0.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   ifft_data               : {real, imag}; imag is ignored
//   ifft_user               : sample index within the frame
//   ifft_valid / ifft_ready : input handshake
//   output_data             : OUT_W signed audio sample
//   output_valid / _ready   : output handshake
//   sat_flag                : sticky saturation indicator
module overlap_add_synth
    import ola_pkg::*;
#(
    parameter int unsigned FFT_LEN     = 4096,
    parameter int unsigned HOP         = 1024,
    parameter int unsigned DATA_W      = 18,
    parameter int unsigned OUT_W       = 16,
    parameter int unsigned SCALE_SHIFT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2*DATA_W-1:0]        ifft_data,
    input  logic [$clog2(FFT_LEN)-1:0] ifft_user,
    input  logic                       ifft_valid,
    output logic                       ifft_ready,
    output logic [OUT_W-1:0]           output_data,
    output logic                       output_valid,
    input  logic                       output_ready,
    output logic                       sat_flag
);

    localparam int unsigned AW    = ola_addr_w(FFT_LEN);
    localparam int unsigned ACC_W = ola_acc_w(DATA_W, FFT_LEN, HOP);
    localparam int unsigned CW    = AW + 1;

    localparam logic [CW-1:0] FrameCnt  = CW'(FFT_LEN);
    localparam logic [CW-1:0] ClearLast = CW'(FFT_LEN - 1);
    localparam logic [CW-1:0] HopCnt    = CW'(HOP);
    localparam logic [CW-1:0] HopLast   = CW'(HOP - 1);
    localparam logic [AW-1:0] HopStep   = AW'(HOP);

    ola_state_e state_q, state_d;

    logic [AW-1:0]     base_q, base_d;
    logic [CW-1:0]     cnt_q, cnt_d;          // clear index / accept count / drain reads issued
    logic [CW-1:0]     out_cnt_q, out_cnt_d;  // drain transfers completed
    logic              pend_q, pend_d;        // RMW write-back pending this cycle
    logic [AW-1:0]     pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] pend_real_q, pend_real_d;
    logic              rd_valid_q, rd_valid_d;
    logic [OUT_W-1:0]  fifo_q [2];
    logic [OUT_W-1:0]  fifo_d [2];
    logic              fifo_wr_q, fifo_wr_d;
    logic              fifo_rd_q, fifo_rd_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;
    logic              sat_q, sat_d;

    logic              accept;
    logic              pop;
    logic [1:0]        held;
    logic              drain_issue;
    logic              last_xfer;
    logic              fifo_push;
    logic              fifo_pop;

    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [AW-1:0]     ram_raddr;
    logic [ACC_W-1:0]  ram_wdata;
    logic [ACC_W-1:0]  ram_rdata;

    logic signed [ACC_W-1:0] acc_shifted;
    logic [OUT_W-1:0]        conv_data;
    logic                    conv_sat;

    logic unused_imag;
    assign unused_imag = ^ifft_data[DATA_W-1:0];

    ola_accum_ram #(
        .DEPTH (FFT_LEN),
        .WIDTH (ACC_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // ---------------------------------------------------------------- FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM next state
    // ACCUM lingers one cycle after the last accept (cnt_q == FrameCnt) so the
    // final write-back lands before the first drain read.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear: if (cnt_q == ClearLast) state_d = StAccum;
            StAccum: if (cnt_q == FrameCnt) state_d = StDrain;
            StDrain: if (last_xfer) state_d = StAccum;
            default: state_d = StClear;
        endcase
    end

    // ---------------------------------------------------------------- FSM outputs
    // The head of the skid buffer wins; with an empty skid the RAM read data
    // is presented directly, which gives one output per cycle.
    always_comb begin
        ifft_ready   = (state_q == StAccum) && (cnt_q != FrameCnt);
        output_valid = (fifo_cnt_q != 2'd0) || rd_valid_q;
        output_data  = '0;
        if (fifo_cnt_q != 2'd0) begin
            output_data = fifo_q[fifo_rd_q];
        end else if (rd_valid_q) begin
            output_data = conv_data;
        end
        sat_flag = sat_q;
    end

    // ---------------------------------------------------------------- handshake control
    // A drain read is issued only if the skid can still absorb it should the
    // consumer stall: after this cycle at most one sample may be held.
    always_comb begin
        accept      = ifft_valid && ifft_ready;
        pop         = output_valid && output_ready;
        held        = fifo_cnt_q + {1'b0, rd_valid_q} - {1'b0, pop};
        drain_issue = (state_q == StDrain) && (cnt_q != HopCnt) && (held <= 2'd1);
        last_xfer   = (state_q == StDrain) && pop && (out_cnt_q == HopLast);
    end

    // ---------------------------------------------------------------- RAM ports
    always_comb begin
        ram_raddr = base_q + ((state_q == StDrain) ? cnt_q[AW-1:0] : ifft_user);
        ram_we    = 1'b0;
        ram_waddr = cnt_q[AW-1:0];
        ram_wdata = '0;
        if (state_q == StClear) begin
            ram_we = 1'b1;
        end else if (pend_q) begin
            ram_we    = 1'b1;
            ram_waddr = pend_addr_q;
            ram_wdata = ram_rdata + ACC_W'($signed(pend_real_q));
        end else if (drain_issue) begin
            // Zero behind the read; the read port returns the old contents.
            ram_we    = 1'b1;
            ram_waddr = ram_raddr;
        end
    end

    // ---------------------------------------------------------------- output conversion
    always_comb begin
        acc_shifted = $signed(ram_rdata) >>> SCALE_SHIFT;
`ifdef OVERLAP_ADD_SATURATE_EN
        conv_sat  = 1'b0;
        conv_data = OUT_W'(sat_to_width(longint'(acc_shifted), OUT_W, conv_sat));
`else
        conv_sat  = 1'b0;
        conv_data = OUT_W'(acc_shifted);
`endif
    end

    // ---------------------------------------------------------------- datapath next state
    always_comb begin
        base_d      = base_q;
        cnt_d       = cnt_q;
        out_cnt_d   = out_cnt_q;
        pend_d      = accept;
        pend_addr_d = ram_raddr;
        pend_real_d = ifft_data[2*DATA_W-1:DATA_W];
        rd_valid_d  = drain_issue;

        unique case (state_q)
            StClear: begin
                cnt_d = (cnt_q == ClearLast) ? '0 : cnt_q + CW'(1);
            end
            StAccum: begin
                if (cnt_q == FrameCnt) begin
                    cnt_d = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDrain: begin
                if (drain_issue) cnt_d = cnt_q + CW'(1);
                if (pop) out_cnt_d = out_cnt_q + CW'(1);
                if (last_xfer) begin
                    cnt_d     = '0;
                    out_cnt_d = '0;
                    base_d    = base_q + HopStep;
                end
            end
            default: ;
        endcase

        // Skid: RAM data is captured unless it leaves straight to the consumer.
        fifo_pop   = pop && (fifo_cnt_q != 2'd0);
        fifo_push  = rd_valid_q && !(pop && (fifo_cnt_q == 2'd0));
        fifo_d     = fifo_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        if (fifo_push) begin
            fifo_d[fifo_wr_q] = conv_data;
            fifo_wr_d         = ~fifo_wr_q;
        end
        if (fifo_pop) begin
            fifo_rd_d = ~fifo_rd_q;
        end
        fifo_cnt_d = fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};

        sat_d = sat_q | (rd_valid_q & conv_sat);
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= '0;
            cnt_q       <= '0;
            out_cnt_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_real_q <= '0;
            rd_valid_q  <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            fifo_wr_q   <= 1'b0;
            fifo_rd_q   <= 1'b0;
            fifo_cnt_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            out_cnt_q   <= out_cnt_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_real_q <= pend_real_d;
            rd_valid_q  <= rd_valid_d;
            fifo_q[0]   <= fifo_d[0];
            fifo_q[1]   <= fifo_d[1];
            fifo_wr_q   <= fifo_wr_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_cnt_q  <= fifo_cnt_d;
            sat_q       <= sat_d;
        end
    end

endmodule

// File: tb/tb_overlap_add_synth.sv
// Directed bench for overlap_add_synth with FFT_LEN=16, HOP=4, SCALE_SHIFT=0.
module tb_overlap_add_synth;

    logic               clk;
    logic               rst;
    logic [35:0]        ifft_data;
    logic [3:0]         ifft_user;
    logic               ifft_valid;
    logic               ifft_ready;
    logic signed [15:0] output_data;
    logic               output_valid;
    logic               output_ready;
    logic               sat_flag;

    int n_checks = 0;
    int n_fail   = 0;

    overlap_add_synth #(
        .FFT_LEN     (16),
        .HOP         (4),
        .DATA_W      (18),
        .OUT_W       (16),
        .SCALE_SHIFT (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ifft_data    (ifft_data),
        .ifft_user    (ifft_user),
        .ifft_valid   (ifft_valid),
        .ifft_ready   (ifft_ready),
        .output_data  (output_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .sat_flag     (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit do_reset;
        bit bitrev;
        int real_val;
        int exp_wrap;
        int exp_clamp;
        bit flag_clamp;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] bitrev4(input int i);
        logic [3:0] v;
        v = i[3:0];
        return {v[0], v[1], v[2], v[3]};
    endfunction

    task automatic do_reset(input string tag);
        int n;
        rst        = 1'b1;
        ifft_valid = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_rst_ifft_ready"}, int'(ifft_ready), 0);
        check({tag, "_rst_output_valid"}, int'(output_valid), 0);
        check({tag, "_rst_output_data"}, int'(output_data), 0);
        check({tag, "_rst_sat_flag"}, int'(sat_flag), 0);
        rst = 1'b0;
        n   = 0;
        while (!ifft_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_clear_cycles"}, n, 16);
    endtask

    // Sends 16 samples; real = rv (+ index when ramp). Ends on the cycle after the last accept.
    task automatic send_frame(input string tag, input int rv, input bit br, input bit ramp);
        int i;
        int t;
        int idx;
        bit acc;
        logic [17:0] re;
        i = 0;
        t = 0;
        while (i < 16 && t < 200) begin
            idx        = br ? int'(bitrev4(i)) : i;
            re         = 18'(rv + (ramp ? idx : 0));
            ifft_valid = 1'b1;
            ifft_user  = 4'(idx);
            ifft_data  = {re, 18'h2A5A5};
            acc        = ifft_ready;
            @(negedge clk);
            t++;
            if (acc) i++;
        end
        ifft_valid = 1'b0;
        check({tag, "_accepts"}, i, 16);
        check({tag, "_ready_falls"}, int'(ifft_ready), 0);
    endtask

    task automatic drain(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        int k;
        int t;
        int first_t;
        int last_t;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        output_ready = 1'b1;
        k = 0; t = 0; first_t = 0; last_t = 0;
        while (k < 4 && t < 200) begin
            @(negedge clk);
            t++;
            if (output_valid) begin
                if (k == 0) first_t = t;
                last_t = t;
                check($sformatf("%s_out%0d", tag, k), int'(output_data), e[k]);
                if (k == 3) check({tag, "_ready_low_last"}, int'(ifft_ready), 0);
                k++;
            end
        end
        check({tag, "_out_count"}, k, 4);
        check({tag, "_first_latency"}, first_t, 2);
        check({tag, "_back_to_back"}, last_t - first_t, 3);
        @(negedge clk);
        check({tag, "_ready_rises"}, int'(ifft_ready), 1);
        check({tag, "_valid_drops"}, int'(output_valid), 0);
    endtask

    task automatic run_frame(input string tag, input int rv, input bit br, input bit ramp,
                             input int e0, input int e1, input int e2, input int e3,
                             input bit flag);
        send_frame(tag, rv, br, ramp);
        drain(tag, e0, e1, e2, e3);
        check({tag, "_sat_flag"}, int'(sat_flag), int'(flag));
    endtask

    initial begin
        int exp_v;
        bit exp_f;
        int k;
        int t;

        rst          = 1'b1;
        ifft_valid   = 1'b0;
        ifft_data    = '0;
        ifft_user    = '0;
        output_ready = 1'b1;

        // {reset first, bit-reversed, real, expected (wrap), expected (clamp), sat_flag (clamp)}
        vecs[0]  = '{1'b1, 1'b0, 1, 1, 1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1, 2, 2, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1, 3, 3, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1, 4, 4, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1, 4, 4, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1, 1, 1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1, 2, 2, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1, 3, 3, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1, 4, 4, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1, 4, 4, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 30000, 30000, 30000, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 30000, -5536, 32767, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 30000, 24464, 32767, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 30000, -11072, 32767, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 30000, -11072, 32767, 1'b1};
        vecs[15] = '{1'b1, 1'b0, -2, -2, -2, 1'b0};
        vecs[16] = '{1'b0, 1'b0, -2, -4, -4, 1'b0};

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].do_reset) do_reset($sformatf("v%0d", i));
`ifdef OVERLAP_ADD_SATURATE_EN
            exp_v = vecs[i].exp_clamp;
            exp_f = vecs[i].flag_clamp;
`else
            exp_v = vecs[i].exp_wrap;
            exp_f = 1'b0;
`endif
            run_frame($sformatf("v%0d", i), vecs[i].real_val, vecs[i].bitrev, 1'b0,
                      exp_v, exp_v, exp_v, exp_v, exp_f);
        end

        // Consumer stall mid-drain, with junk offered on the input while not ready.
        do_reset("stall");
        send_frame("stall", 1, 1'b0, 1'b1);
        ifft_valid = 1'b1;
        ifft_user  = 4'd0;
        ifft_data  = {18'd1000, 18'h0};
        k = 0;
        t = 0;
        while (k < 1 && t < 50) begin
            @(negedge clk);
            t++;
            if (output_valid) begin
                check("stall_out0", int'(output_data), 1);
                k++;
            end
        end
        @(posedge clk);
        #1;
        output_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check($sformatf("stall_valid%0d", s), int'(output_valid), 1);
            check($sformatf("stall_hold%0d", s), int'(output_data), 2);
            check($sformatf("stall_ready%0d", s), int'(ifft_ready), 0);
        end
        output_ready = 1'b1;
        while (k < 4 && t < 100) begin
            if (output_valid) begin
                check($sformatf("stall_out%0d", k), int'(output_data), k + 1);
                check($sformatf("stall_ready_out%0d", k), int'(ifft_ready), 0);
                if (k == 3) ifft_valid = 1'b0;
                k++;
            end
            @(negedge clk);
            t++;
        end
        ifft_valid = 1'b0;
        check("stall_out_count", k, 4);
        check("stall_ready_rises", int'(ifft_ready), 1);
        check("stall_valid_drops", int'(output_valid), 0);
        // Positions 4..7 still hold 5..8; junk must not have landed anywhere.
        run_frame("stall_next", 0, 1'b0, 1'b0, 5, 6, 7, 8, 1'b0);

        // Reset in the middle of the second drain.
        do_reset("mid");
        run_frame("mid_f1", 1, 1'b0, 1'b0, 1, 1, 1, 1, 1'b0);
        send_frame("mid_f2", 1, 1'b0, 1'b0);
        k = 0;
        t = 0;
        while (k < 2 && t < 50) begin
            @(negedge clk);
            t++;
            if (output_valid) begin
                check($sformatf("mid_f2_out%0d", k), int'(output_data), 2);
                k++;
            end
        end
        check("mid_f2_partial", k, 2);
        do_reset("mid_rst");
        run_frame("mid_fresh", 1, 1'b0, 1'b0, 1, 1, 1, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
